// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle for the multicycle controller.
// master = controller side, slave = datapath side driving instruction fields and flags.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;
  logic       err;

  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output pc_write, ir_write, reg_write, mem_write, adr_src,
           alu_src_a, alu_src_b, result_src, imm_src, alu_control,
           state, err
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  pc_write, ir_write, reg_write, mem_write, adr_src,
           alu_src_a, alu_src_b, result_src, imm_src, alu_control,
           state, err
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style main controller with memory wait timeout and sticky ERROR state.
// Optional macro MULTICYCLE_IMM_ALU_EN enables the I-type ALU path (DECODE -> EXECI).
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_controller_if.master        ctrl_if
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_BEQ      = 4'd9,
    S_ERROR    = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  logic       pc_write, ir_write, reg_write, mem_write, adr_src;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_control;
  logic       waiting;

  function automatic logic [2:0] funct_op(input logic [2:0] f3, input logic f7b5,
                                          input logic op5);
    case (f3)
      3'b000:  return (f7b5 && op5) ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = ALU_ADD;
    waiting     = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (ctrl_if.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (ctrl_if.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (ctrl_if.funct3 == 3'b000 || ctrl_if.funct3 == 3'b010 ||
                ctrl_if.funct3 == 3'b110 || ctrl_if.funct3 == 3'b111)
              state_d = S_EXECR;
            else
              state_d = S_ERROR;
          end
          OP_BRANCH: state_d = S_BEQ;
`ifdef MULTICYCLE_IMM_ALU_EN
          OP_IMM:    state_d = S_EXECI;
`endif
          default:   state_d = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = ctrl_if.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (ctrl_if.mem_ready) state_d = S_MEMWB;
        else                   waiting = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (ctrl_if.mem_ready) state_d = S_FETCH;
        else                   waiting = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = funct_op(ctrl_if.funct3, ctrl_if.funct7b5, ctrl_if.opcode[5]);
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = funct_op(ctrl_if.funct3, ctrl_if.funct7b5, ctrl_if.opcode[5]);
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = ctrl_if.zero;
        state_d     = S_FETCH;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase

    // The cycle that exhausts the wait budget issues nothing and leaves for ERROR.
    if (waiting && wait_q >= WAIT_LAST) begin
      state_d   = S_ERROR;
      mem_write = 1'b0;
    end

    if (state_d != state_q || ctrl_if.mem_ready) wait_d = 8'd0;
    else if (waiting)                           wait_d = wait_q + 8'd1;
    else                                        wait_d = wait_q;

    // During reset the state register already reads FETCH; only the strobes need gating.
    if (!rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign ctrl_if.pc_write    = pc_write;
  assign ctrl_if.ir_write    = ir_write;
  assign ctrl_if.reg_write   = reg_write;
  assign ctrl_if.mem_write   = mem_write;
  assign ctrl_if.adr_src     = adr_src;
  assign ctrl_if.alu_src_a   = alu_src_a;
  assign ctrl_if.alu_src_b   = alu_src_b;
  assign ctrl_if.result_src  = result_src;
  assign ctrl_if.alu_control = alu_control;
  assign ctrl_if.imm_src     = (ctrl_if.opcode == OP_STORE)  ? 2'b01 :
                               (ctrl_if.opcode == OP_BRANCH) ? 2'b10 : 2'b00;
  assign ctrl_if.state       = state_q;
  assign ctrl_if.err         = (state_q == S_ERROR);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed + randomized bench for multicycle_controller: per-instruction state/strobe model
// with a per-cycle expected queue of (state, mem_ready).
module tb_multicycle_controller;

  localparam int TMO = 15;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                         MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, ALUWB = 4'd7,
                         EXECI = 4'd8, BEQ = 4'd9, ERROR = 4'd10;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         BR = 7'b1100011, IMM = 7'b0010011, BAD = 7'b0110111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller #(.TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];
  logic       mr_q[$];

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;
  logic       cur_zero;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_alu_funct();
    case (cur_f3)
      3'b000:  return (cur_f7 && cur_op[5]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Compare every output against the per-state rule table for state s with mem_ready mr.
  task automatic check_outputs(input logic [3:0] s, input logic mr);
    logic [1:0] ea, eb, er, ei;
    logic [2:0] ealu;
    ea = (s == DECODE) ? 2'b01 :
         (s == MEMADR || s == EXECR || s == EXECI || s == BEQ) ? 2'b10 : 2'b00;
    eb = (s == FETCH) ? 2'b10 : (s == DECODE || s == MEMADR || s == EXECI) ? 2'b01 : 2'b00;
    er = (s == FETCH) ? 2'b10 : (s == MEMWB) ? 2'b01 : 2'b00;
    ei = (cur_op == SW) ? 2'b01 : (cur_op == BR) ? 2'b10 : 2'b00;
    ealu = (s == EXECR || s == EXECI) ? exp_alu_funct() : (s == BEQ) ? 3'b001 : 3'b000;
    check("state",      32'(bus.state),      32'(s));
    check("err",        32'(bus.err),        32'(s == ERROR));
    check("ir_write",   32'(bus.ir_write),   32'(s == FETCH && mr));
    check("pc_write",   32'(bus.pc_write),   32'((s == FETCH && mr) || (s == BEQ && cur_zero)));
    check("reg_write",  32'(bus.reg_write),  32'(s == MEMWB || s == ALUWB));
    check("mem_write",  32'(bus.mem_write),  32'(s == MEMWRITE));
    check("adr_src",    32'(bus.adr_src),    32'(s == MEMREAD || s == MEMWRITE));
    check("alu_src_a",  32'(bus.alu_src_a),  32'(ea));
    check("alu_src_b",  32'(bus.alu_src_b),  32'(eb));
    check("result_src", 32'(bus.result_src), 32'(er));
    check("imm_src",    32'(bus.imm_src),    32'(ei));
    check("alu_control", 32'(bus.alu_control), 32'(ealu));
  endtask

  // ---------------- reference model: instruction -> cycle plan ----------------
  task automatic push1(input logic [3:0] s);
    exp_q.push_back(s);
    mr_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic push_wait(input logic [3:0] s, input int lat, output bit timed_out);
    timed_out = 1'b0;
    if (lat >= TMO) begin
      repeat (TMO) begin exp_q.push_back(s); mr_q.push_back(1'b0); end
      timed_out = 1'b1;
    end else begin
      repeat (lat) begin exp_q.push_back(s); mr_q.push_back(1'b0); end
      exp_q.push_back(s); mr_q.push_back(1'b1);
    end
  endtask

  task automatic plan_instr(input int fl, input int ml, output bit ends_err);
    bit to;
    ends_err = 1'b0;
    push_wait(FETCH, fl, to);
    if (to) ends_err = 1'b1;
    else begin
      push1(DECODE);
      case (cur_op)
        LW: begin push1(MEMADR); push_wait(MEMREAD, ml, to); if (!to) push1(MEMWB); ends_err = to; end
        SW: begin push1(MEMADR); push_wait(MEMWRITE, ml, to); ends_err = to; end
        RT: begin
          if (cur_f3 inside {3'b000, 3'b010, 3'b110, 3'b111}) begin push1(EXECR); push1(ALUWB); end
          else ends_err = 1'b1;
        end
        BR: push1(BEQ);
`ifdef MULTICYCLE_IMM_ALU_EN
        IMM: begin push1(EXECI); push1(ALUWB); end
`endif
        default: ends_err = 1'b1;
      endcase
    end
    if (ends_err) repeat (3) push1(ERROR);
  endtask

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z);
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_zero = z;
    bus.opcode = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
  endtask

  task automatic run_plan(input int max_cycles);
    int n = 0;
    logic [3:0] s;
    logic mr;
    while (exp_q.size() > 0 && (max_cycles < 0 || n < max_cycles)) begin
      s  = exp_q.pop_front();
      mr = mr_q.pop_front();
      bus.mem_ready = mr;
      #1;
      check_outputs(s, mr);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check("rst_async_state", 32'(bus.state), 32'(FETCH));
    check_outputs(FETCH, 1'b0);
    @(posedge clk);
    #1;
    check("rst_hold_state", 32'(bus.state), 32'(FETCH));
    check("rst_hold_ir", 32'(bus.ir_write), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    mr_q.delete();
  endtask

  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic z, input int fl, input int ml);
    bit e;
    set_instr(op, f3, f7, z);
    plan_instr(fl, ml, e);
    run_plan(-1);
    if (e) do_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    set_instr(LW, 3'b000, 1'b0, 1'b0);
    bus.mem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    do_instr(LW, 3'b010, 1'b0, 1'b0, 0, 0);      // lw, memory always ready
    do_instr(SW, 3'b010, 1'b0, 1'b0, 0, 3);      // sw, 3 stall cycles -> 4 mem_write cycles
    do_instr(BR, 3'b000, 1'b0, 1'b1, 1, 0);      // beq taken
    do_instr(BR, 3'b000, 1'b0, 1'b0, 0, 0);      // beq not taken
    do_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0);      // sub
    do_instr(RT, 3'b110, 1'b0, 1'b0, 2, 0);      // or
    do_instr(RT, 3'b001, 1'b0, 1'b0, 0, 0);      // unsupported funct3 -> ERROR
    do_instr(IMM, 3'b000, 1'b1, 1'b0, 0, 0);     // addi (path depends on build)
    do_instr(LW, 3'b000, 1'b0, 1'b0, 20, 0);     // fetch timeout
    do_instr(LW, 3'b000, 1'b0, 1'b0, 0, 20);     // memread timeout

    // Reset in the middle of a stalled store, then a clean instruction from FETCH.
    set_instr(SW, 3'b010, 1'b0, 1'b0);
    begin
      bit e;
      plan_instr(0, 10, e);
    end
    run_plan(5);
    do_reset();
    do_instr(LW, 3'b010, 1'b0, 1'b0, 0, 1);

    for (int i = 0; i < 60; i++) begin
      logic [6:0] op;
      case ($urandom_range(0, 5))
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = BR;
        4: op = IMM;
        default: op = BAD;
      endcase
      do_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
